vote_collector: RTL and testbench

- Upstream stage of the combinational vote tallier: collects ballots one per cycle from a serial ballot bus and builds the voter bit-vectors np, vip and vvip.
- The tallier consumes these vectors directly.
- A session FSM opens and closes voting, rejects bad or duplicate ballots, auto-closes when every voter has voted, and holds the vectors stable after close.

---
 rtl/vote_collector.sv | 177 +++++++++++++++++
 tb/tb_vote_collector.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vote_collector.sv
// Purpose : collects serial ballots into the np/vip/vvip yes-vectors consumed by the vote tallier.
// Latency : 1 cycle from ballot to updated vector / cast_cnt / err.
// Backpressure: none; one ballot per cycle is always accepted or rejected (err pulse).
//
// Ports: clk, reset (sync, active-high); start/close session control;
//        b_valid/b_class/b_id/b_yes ballot bus; np/vip/vvip registered yes-vectors;
//        cast_cnt accepted-ballot count; busy (OPEN), done (1-cycle close pulse),
//        err (1-cycle reject pulse).
// Option : define VOTE_REVOTE_EN to let a voter overwrite an earlier ballot.
//          In that case the overwrite is not counted and raises no err.
module vote_collector #(
    parameter int NP_W  = 32,
    parameter int VIP_W = 8,
    parameter int CNT_W = 6     // 2**CNT_W must exceed NP_W+VIP_W+1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             close,
    input  logic             b_valid,
    input  logic [1:0]       b_class,
    input  logic [4:0]       b_id,
    input  logic             b_yes,
    output logic [NP_W-1:0]  np,
    output logic [VIP_W-1:0] vip,
    output logic             vvip,
    output logic [CNT_W-1:0] cast_cnt,
    output logic             busy,
    output logic             done,
    output logic             err
);

    localparam int TOTAL = NP_W + VIP_W + 1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_OPEN   = 2'd1,
        S_CLOSED = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [NP_W-1:0]  np_mask;
    logic [VIP_W-1:0] vip_mask;
    logic             vvip_mask;

    // One-hot target of the current ballot; all-zero when out of range.
    logic [NP_W-1:0]  np_sel;
    logic [VIP_W-1:0] vip_sel;
    logic             vvip_sel;
    logic             in_range;
    logic             already;

    logic             clear;
    logic             accept;
    logic             count;
    logic             reject;

    // Ballot decode.
    always_comb begin
        np_sel   = '0;
        vip_sel  = '0;
        vvip_sel = 1'b0;
        in_range = 1'b0;
        already  = 1'b0;
        case (b_class)
            2'd0: if (32'(b_id) < NP_W) begin
                in_range = 1'b1;
                np_sel   = NP_W'(1) << b_id;
                already  = |(np_mask & np_sel);
            end
            2'd1: if (32'(b_id) < VIP_W) begin
                in_range = 1'b1;
                vip_sel  = VIP_W'(1) << b_id;
                already  = |(vip_mask & vip_sel);
            end
            2'd2: if (b_id == 5'd0) begin
                in_range = 1'b1;
                vvip_sel = 1'b1;
                already  = vvip_mask;
            end
            default: ;
        endcase
    end

    // Session FSM: next state and per-cycle actions.
    always_comb begin
        state_nxt = state;
        clear     = 1'b0;
        accept    = 1'b0;
        count     = 1'b0;
        reject    = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = S_OPEN;
                    clear     = 1'b1;
                end
            end
            S_OPEN: begin
                // A restart drops any ballot arriving in the same cycle.
                if (start) begin
                    clear = 1'b1;
                end else begin
                    if (b_valid) begin
`ifdef VOTE_REVOTE_EN
                        if (in_range) begin
                            accept = 1'b1;
                            count  = !already;
                        end else begin
                            reject = 1'b1;
                        end
`else
                        if (in_range && !already) begin
                            accept = 1'b1;
                            count  = 1'b1;
                        end else begin
                            reject = 1'b1;
                        end
`endif
                    end
                    // The ballot of this cycle is still folded in before closing.
                    if (close || (count && cast_cnt == CNT_W'(TOTAL - 1)))
                        state_nxt = S_CLOSED;
                end
            end
            S_CLOSED: begin
                if (start) begin
                    state_nxt = S_OPEN;
                    clear     = 1'b1;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            np        <= '0;
            vip       <= '0;
            vvip      <= 1'b0;
            np_mask   <= '0;
            vip_mask  <= '0;
            vvip_mask <= 1'b0;
            cast_cnt  <= '0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            state <= state_nxt;
            done  <= (state_nxt == S_CLOSED) && (state != S_CLOSED);
            err   <= reject;
            if (clear) begin
                np        <= '0;
                vip       <= '0;
                vvip      <= 1'b0;
                np_mask   <= '0;
                vip_mask  <= '0;
                vvip_mask <= 1'b0;
                cast_cnt  <= '0;
            end else if (accept) begin
                np        <= (np  & ~np_sel)  | (b_yes ? np_sel  : '0);
                vip       <= (vip & ~vip_sel) | (b_yes ? vip_sel : '0);
                if (vvip_sel)
                    vvip  <= b_yes;
                np_mask   <= np_mask  | np_sel;
                vip_mask  <= vip_mask | vip_sel;
                vvip_mask <= vvip_mask | vvip_sel;
                if (count && cast_cnt != CNT_W'(TOTAL))
                    cast_cnt <= cast_cnt + 1'b1;
            end
        end
    end

    assign busy = (state == S_OPEN);

endmodule

// File: tb/tb_vote_collector.sv
module tb_vote_collector;

    logic        clk;
    logic        reset;
    logic        start;
    logic        close;
    logic        b_valid;
    logic [1:0]  b_class;
    logic [4:0]  b_id;
    logic        b_yes;
    logic [31:0] np;
    logic [7:0]  vip;
    logic        vvip;
    logic [5:0]  cast_cnt;
    logic        busy;
    logic        done;
    logic        err;

    vote_collector dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .close    (close),
        .b_valid  (b_valid),
        .b_class  (b_class),
        .b_id     (b_id),
        .b_yes    (b_yes),
        .np       (np),
        .vip      (vip),
        .vvip     (vvip),
        .cast_cnt (cast_cnt),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [31:0] np;
        logic [7:0]  vip;
        logic        vvip;
        logic [5:0]  cnt;
        logic        busy;
        logic        done;
        logic        err;
    } snap_t;

    snap_t exp_q[$];
    int    checks = 0;
    int    errors = 0;

    // Reference model: per-voter arrays and a plain session phase.
    int  m_phase;              // 0 idle, 1 open, 2 closed
    bit  m_np_yes[32];
    bit  m_np_voted[32];
    bit  m_vip_yes[8];
    bit  m_vip_voted[8];
    bit  m_vvip_yes;
    bit  m_vvip_voted;
    int  m_cnt;
    bit  m_done;
    bit  m_err;

    task automatic m_clear();
        for (int i = 0; i < 32; i++) begin m_np_yes[i] = 0; m_np_voted[i] = 0; end
        for (int i = 0; i < 8; i++)  begin m_vip_yes[i] = 0; m_vip_voted[i] = 0; end
        m_vvip_yes = 0;
        m_vvip_voted = 0;
        m_cnt = 0;
    endtask

    task automatic model_step(input bit rs, input bit st, input bit cl, input bit bv,
                              input int cls, input int id, input bit yes);
        bit ok, dup;
        m_done = 0;
        m_err  = 0;
        if (rs) begin
            m_clear();
            m_phase = 0;
        end else if (m_phase != 1) begin
            if (st) begin m_clear(); m_phase = 1; end
        end else if (st) begin
            m_clear();
        end else begin
            if (bv) begin
                ok  = 0;
                dup = 0;
                if (cls == 0 && id < 32)     begin ok = 1; dup = m_np_voted[id]; end
                else if (cls == 1 && id < 8) begin ok = 1; dup = m_vip_voted[id]; end
                else if (cls == 2 && id == 0) begin ok = 1; dup = m_vvip_voted; end
`ifndef VOTE_REVOTE_EN
                if (dup) ok = 0;
`endif
                if (!ok) begin
                    m_err = 1;
                end else begin
                    if (cls == 0)      begin m_np_yes[id] = yes;  m_np_voted[id] = 1; end
                    else if (cls == 1) begin m_vip_yes[id] = yes; m_vip_voted[id] = 1; end
                    else               begin m_vvip_yes = yes;    m_vvip_voted = 1; end
                    if (!dup) m_cnt++;
                end
            end
            if (cl || m_cnt == 41) begin
                m_phase = 2;
                m_done  = 1;
            end
        end
    endtask

    function automatic snap_t model_snap();
        snap_t s;
        for (int i = 0; i < 32; i++) s.np[i] = m_np_yes[i];
        for (int i = 0; i < 8; i++)  s.vip[i] = m_vip_yes[i];
        s.vvip = m_vvip_yes;
        s.cnt  = 6'(m_cnt);
        s.busy = (m_phase == 1);
        s.done = m_done;
        s.err  = m_err;
        return s;
    endfunction

    // Drive one cycle of inputs (applied at the next edge) and queue the expected result.
    task automatic cycle(input bit rs, input bit st, input bit cl, input bit bv,
                         input int cls, input int id, input bit yes);
        @(posedge clk);
        #2;
        reset   = rs;
        start   = st;
        close   = cl;
        b_valid = bv;
        b_class = 2'(cls);
        b_id    = 5'(id);
        b_yes   = yes;
        model_step(rs, st, cl, bv, cls, id, yes);
        exp_q.push_back(model_snap());
    endtask

    task automatic ballot(input int cls, input int id, input bit yes);
        cycle(0, 0, 0, 1, cls, id, yes);
    endtask

    task automatic idle();
        cycle(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    // Monitor: one expected snapshot per driven cycle, compared just after the edge.
    initial begin
        snap_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if (np !== e.np || vip !== e.vip || vvip !== e.vvip || cast_cnt !== e.cnt ||
                    busy !== e.busy || done !== e.done || err !== e.err) begin
                    errors++;
                    $display("FAIL cycle_snapshot @%0t: got np=%h vip=%h vvip=%b cnt=%0d busy=%b done=%b err=%b, required np=%h vip=%h vvip=%b cnt=%0d busy=%b done=%b err=%b",
                             $time, np, vip, vvip, cast_cnt, busy, done, err,
                             e.np, e.vip, e.vvip, e.cnt, e.busy, e.done, e.err);
                end
            end
        end
    end

    initial begin
        int ids[8] = '{3, 6, 7, 18, 19, 21, 23, 27};
        logic [31:0] np_req;
        int wait_cyc;

        reset = 1; start = 0; close = 0; b_valid = 0; b_class = 0; b_id = 0; b_yes = 0;
        m_phase = 0;
        m_done = 0;
        m_err = 0;
        m_clear();

        // Reset state.
        cycle(1, 0, 0, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 0, 0, 0);
        idle();
        check_val("reset_np", np, 32'h0);
        check_val("reset_busy", {31'b0, busy}, 32'h0);

        // Basic build-up.
        cycle(0, 1, 0, 0, 0, 0, 0);
        np_req = '0;
        foreach (ids[i]) begin
            ballot(0, ids[i], 1);
            np_req[ids[i]] = 1'b1;
        end
        ballot(1, 0, 1);
        ballot(1, 2, 1);
        ballot(2, 0, 1);
        cycle(0, 0, 1, 0, 0, 0, 0);
        idle();
        check_val("basic_np", np, np_req);
        check_val("basic_vip", {24'b0, vip}, 32'h05);
        check_val("basic_vvip", {31'b0, vvip}, 32'h1);
        check_val("basic_cnt", {26'b0, cast_cnt}, 32'd11);
        check_val("basic_done", {31'b0, done}, 32'h1);
        check_val("basic_busy", {31'b0, busy}, 32'h0);
        idle();
        check_val("basic_done_drop", {31'b0, done}, 32'h0);

        // Invalid ballots, including a duplicate.
        cycle(0, 1, 0, 0, 0, 0, 0);
        ballot(0, 3, 1);
        ballot(3, 0, 1);
        ballot(1, 9, 1);
        ballot(2, 1, 1);
        ballot(0, 3, 0);
        idle();
`ifdef VOTE_REVOTE_EN
        check_val("revote_np3", {31'b0, np[3]}, 32'h0);
        check_val("revote_cnt", {26'b0, cast_cnt}, 32'd1);
        check_val("revote_err", {31'b0, err}, 32'h0);
`else
        check_val("dup_err", {31'b0, err}, 32'h1);
        check_val("dup_np", np, 32'h8);
        check_val("dup_cnt", {26'b0, cast_cnt}, 32'd1);
`endif

        // Auto-close with every voter.
        cycle(0, 1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 32; i++) ballot(0, i, 1);
        for (int i = 0; i < 8; i++)  ballot(1, i, 1);
        ballot(2, 0, 1);
        ballot(0, 5, 0);
        check_val("auto_done", {31'b0, done}, 32'h1);
        check_val("auto_np", np, 32'hffffffff);
        check_val("auto_vip", {24'b0, vip}, 32'hff);
        check_val("auto_cnt", {26'b0, cast_cnt}, 32'd41);
        check_val("auto_busy", {31'b0, busy}, 32'h0);
        idle();
        check_val("auto_noerr", {31'b0, err}, 32'h0);

        // Ballot together with close.
        cycle(0, 1, 0, 0, 0, 0, 0);
        cycle(0, 0, 1, 1, 0, 7, 1);
        idle();
        check_val("simul_np7", {31'b0, np[7]}, 32'h1);
        check_val("simul_done", {31'b0, done}, 32'h1);

        // Start together with close while open.
        cycle(0, 1, 0, 0, 0, 0, 0);
        ballot(0, 1, 1);
        ballot(1, 1, 1);
        cycle(0, 1, 1, 0, 0, 0, 0);
        idle();
        check_val("restart_busy", {31'b0, busy}, 32'h1);
        check_val("restart_np", np, 32'h0);

        // Reset mid-session, then ballots in IDLE.
        cycle(0, 1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) ballot(0, i + 10, 1);
        cycle(1, 0, 0, 0, 0, 0, 0);
        ballot(0, 2, 1);
        ballot(1, 2, 1);
        idle();
        check_val("midreset_np", np, 32'h0);
        check_val("midreset_cnt", {26'b0, cast_cnt}, 32'd0);

        // Randomized traffic against the model.
        for (int n = 0; n < 1500; n++) begin
            int r;
            int cls;
            r   = $urandom_range(0, 99);
            cls = $urandom_range(0, 3);
            cycle(r == 0, $urandom_range(0, 99) < 4, $urandom_range(0, 99) < 3,
                  $urandom_range(0, 99) < 75, cls,
                  (cls == 0) ? $urandom_range(0, 31) : $urandom_range(0, 9),
                  1'($urandom_range(0, 1)));
        end
        idle();

        // Drain the scoreboard with a bounded wait.
        wait_cyc = 0;
        while (exp_q.size() > 0 && wait_cyc < 10) begin
            @(posedge clk);
            wait_cyc++;
        end
        #3;
        check_val("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
